// File: rtl/coin_change_dispenser_pkg.sv
// Shared vending-controller types: FSM states, coin selection and coin values
// expressed in 5-unit steps. Used by the change dispenser and the coin acceptor.
package coin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    PULSE,
    GAP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    C5,
    C10
  } coin_t;

  localparam int COIN5_STEPS  = 1;
  localparam int COIN10_STEPS = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_change_dispenser_if.sv
// Change-request channel between the vending controller and the dispenser.
interface coin_change_dispenser_if #(
  parameter int AMT_W = 4
);

  // A request transfers on a rising clk edge where req_valid && req_ready are
  // both high; req_amt is sampled at that edge. req_valid may be held or dropped
  // freely while req_ready is low. done pulses for one cycle when the request
  // ends, and short/rem_amt are valid in that same cycle.
  logic             req_valid;
  logic [AMT_W-1:0] req_amt;
  logic             req_ready;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] rem_amt;

  modport master (
    output req_valid,
    output req_amt,
    input  req_ready,
    input  done,
    input  short,
    input  rem_amt
  );

  modport slave (
    input  req_valid,
    input  req_amt,
    output req_ready,
    output done,
    output short,
    output rem_amt
  );

endinterface

// File: rtl/coin_change_dispenser_eject_pulse_timer.sv
// Down-counter for solenoid pulse and gap timing: load a length, expire is high
// in the last cycle of the interval.
module eject_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A value of 1 marks the final cycle, so an interval of N lasts exactly N cycles.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/coin_change_dispenser.sv
// Change dispenser: pays a request out as 10- and 5-coins with timed solenoid
// pulses and tracks tube inventory. Define COIN_DISP_REFILL_EN to add tube refill ports.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int AMT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int INIT5   = 20,
  parameter int INIT10  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  coin_change_dispenser_if.slave  bus,
  output logic                    eject5,
  output logic                    eject10,
  output logic [CNT_W-1:0]        inv5,
  output logic [CNT_W-1:0]        inv10,
  output state_t                  state_dbg
`ifdef COIN_DISP_REFILL_EN
  ,
  input  logic                    load,
  input  logic [CNT_W-1:0]        load5,
  input  logic [CNT_W-1:0]        load10
`endif
);

  localparam int TW = $clog2(max_int(PULSE_W, GAP_W) + 1);

  state_t           state;
  coin_t            pick;
  logic [AMT_W-1:0] remaining;
  logic             ready_q;
  logic             done_q;
  logic             short_q;
  logic [AMT_W-1:0] rem_q;
  logic             accept;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             expire;

`ifdef COIN_DISP_REFILL_EN
  // A refill takes the IDLE cycle, so the request is held off until it is done.
  assign bus.req_ready = ready_q & ~load;
`else
  assign bus.req_ready = ready_q;
`endif

  assign bus.done    = done_q;
  assign bus.short   = short_q;
  assign bus.rem_amt = rem_q;
  assign state_dbg   = state;
  assign accept      = (state == IDLE) && bus.req_valid && bus.req_ready;

  // Largest coin first; a lone odd step can only be paid by a 5-coin.
  always_comb begin
    pick = NONE;
    if (remaining >= AMT_W'(COIN10_STEPS) && inv10 != '0) begin
      pick = C10;
    end else if (remaining >= AMT_W'(COIN5_STEPS) && inv5 != '0) begin
      pick = C5;
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(GAP_W);
    if (state == SEL && pick != NONE) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(PULSE_W);
    end else if (state == PULSE && expire) begin
      tmr_load = 1'b1;
    end
  end

  eject_pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      rem_q     <= '0;
      eject5    <= 1'b0;
      eject10   <= 1'b0;
      inv5      <= CNT_W'(INIT5);
      inv10     <= CNT_W'(INIT10);
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
`ifdef COIN_DISP_REFILL_EN
          if (load) begin
            inv5  <= load5;
            inv10 <= load10;
          end
`endif
          if (accept) begin
            remaining <= bus.req_amt;
            ready_q   <= 1'b0;
            state     <= SEL;
          end
        end
        SEL: begin
          // Inventory drops in the commit cycle, so a tube can never underflow.
          case (pick)
            C10: begin
              remaining <= remaining - AMT_W'(COIN10_STEPS);
              inv10     <= inv10 - CNT_W'(1);
              eject10   <= 1'b1;
              state     <= PULSE;
            end
            C5: begin
              remaining <= remaining - AMT_W'(COIN5_STEPS);
              inv5      <= inv5 - CNT_W'(1);
              eject5    <= 1'b1;
              state     <= PULSE;
            end
            default: begin
              done_q  <= 1'b1;
              short_q <= (remaining != '0);
              rem_q   <= remaining;
              state   <= DONE;
            end
          endcase
        end
        PULSE: begin
          if (expire) begin
            eject5  <= 1'b0;
            eject10 <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (expire) begin
            state <= SEL;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          eject5  <= 1'b0;
          eject10 <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: three instances with different tube fills,
// directed scenarios plus random requests checked against a coin-count model.
module tb_coin_change_dispenser;
  import coin_pkg::*;

  localparam int AMT_W = 4;
  localparam int CNT_W = 8;
  localparam int P     = 4;
  localparam int G     = 2;
  localparam int C     = 1 + P + G;
  localparam int ND    = 3;
  localparam int I5[ND]  = '{20, 20, 0};
  localparam int I10[ND] = '{20, 1, 5};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             rv   [ND];
  logic [AMT_W-1:0] ra   [ND];
  logic             rdy  [ND];
  logic             dn   [ND];
  logic             sh   [ND];
  logic [AMT_W-1:0] rem  [ND];
  logic             e5   [ND];
  logic             e10  [ND];
  logic [CNT_W-1:0] i5   [ND];
  logic [CNT_W-1:0] i10  [ND];
  state_t           st   [ND];
`ifdef COIN_DISP_REFILL_EN
  logic             ld   [ND];
  logic [CNT_W-1:0] ld5  [ND];
  logic [CNT_W-1:0] ld10 [ND];
`endif

  for (genvar g = 0; g < ND; g++) begin : g_dut
    coin_change_dispenser_if #(.AMT_W(AMT_W)) bus ();
    assign bus.req_valid = rv[g];
    assign bus.req_amt   = ra[g];
    assign rdy[g]        = bus.req_ready;
    assign dn[g]         = bus.done;
    assign sh[g]         = bus.short;
    assign rem[g]        = bus.rem_amt;

    coin_change_dispenser #(
      .PULSE_W (P),
      .GAP_W   (G),
      .AMT_W   (AMT_W),
      .CNT_W   (CNT_W),
      .INIT5   (I5[g]),
      .INIT10  (I10[g])
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .eject5    (e5[g]),
      .eject10   (e10[g]),
      .inv5      (i5[g]),
      .inv10     (i10[g]),
      .state_dbg (st[g])
`ifdef COIN_DISP_REFILL_EN
      ,
      .load      (ld[g]),
      .load5     (ld5[g]),
      .load10    (ld10[g])
`endif
    );
  end

  // Scoreboard: model tube counts and per-cycle expected {ready, done, ej10, ej5}.
  int         n_vec = 0;
  int         n_err = 0;
  int         m5 [ND];
  int         m10[ND];
  logic [3:0] exp_q[$];

  function automatic logic [1:0] exp_eject(input int t, input int n10, input int n5);
    int j;
    int ph;
    j  = (t - 1) / C;
    ph = (t - 1) % C;
    if (j >= n10 + n5 || ph < 1 || ph > P) return 2'b00;
    return (j < n10) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < ND; g++) begin
      m5[g]  = I5[g];
      m10[g] = I10[g];
    end
  endtask

  task automatic run_req(input int g, input int amt, input bit hold,
                         output int lat, output int p10, output int p5,
                         output logic osh, output logic [AMT_W-1:0] orem);
    int n10, n5, r, L, t, bad_t, w;
    logic [3:0] got, expv, bad_got, bad_exp;
    logic prev10, prev5;
    n10 = amt / 2;
    if (n10 > m10[g]) n10 = m10[g];
    r  = amt - 2 * n10;
    n5 = (r > m5[g]) ? m5[g] : r;
    r  = r - n5;
    L  = 2 + (n10 + n5) * C;
    exp_q.delete();
    for (int tt = 1; tt <= L; tt++) exp_q.push_back({1'b0, (tt == L), exp_eject(tt, n10, n5)});
    exp_q.push_back(4'b1000);
    lat = -1; p10 = 0; p5 = 0; osh = 1'bx; orem = 'x;
    bad_got = '0; bad_exp = '0;
    @(negedge clk);
    w = 0;
    while (rdy[g] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (rdy[g] !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait dut%0d: req_ready=%b, required 1", g, rdy[g]);
      return;
    end
    rv[g] = 1'b1;
    ra[g] = AMT_W'(amt);
    t = 0; bad_t = 0; prev10 = 1'b0; prev5 = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      t++;
      if (!hold) rv[g] = 1'b0;
      got  = {rdy[g], dn[g], e10[g], e5[g]};
      expv = exp_q.pop_front();
      if (got !== expv && bad_t == 0) begin
        bad_t = t; bad_got = got; bad_exp = expv;
      end
      if (e10[g] === 1'b1 && prev10 !== 1'b1) p10++;
      if (e5[g] === 1'b1 && prev5 !== 1'b1) p5++;
      prev10 = e10[g];
      prev5  = e5[g];
      if (dn[g] === 1'b1 && lat < 0) begin
        lat = t; osh = sh[g]; orem = rem[g];
      end
    end
    rv[g] = 1'b0;
    n_vec++;
    if (bad_t != 0) begin
      n_err++;
      $display("FAIL trace dut%0d amt=%0d: cycle %0d {ready,done,ej10,ej5}=%b, required %b",
               g, amt, bad_t, bad_got, bad_exp);
    end
    n_vec++;
    if (osh !== (r != 0)) begin
      n_err++;
      $display("FAIL short dut%0d amt=%0d: got %b, required %b", g, amt, osh, (r != 0));
    end
    n_vec++;
    if (orem !== AMT_W'(r)) begin
      n_err++;
      $display("FAIL rem_amt dut%0d amt=%0d: got %0d, required %0d", g, amt, orem, r);
    end
    m10[g] -= n10;
    m5[g]  -= n5;
    n_vec++;
    if (i10[g] !== CNT_W'(m10[g]) || i5[g] !== CNT_W'(m5[g])) begin
      n_err++;
      $display("FAIL inventory dut%0d amt=%0d: inv10=%0d inv5=%0d, required %0d %0d",
               g, amt, i10[g], i5[g], m10[g], m5[g]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < ND; g++) begin
      n_vec++;
      if ({rdy[g], e5[g], e10[g], dn[g], sh[g], rem[g]} !== {5'b10000, {AMT_W{1'b0}}}) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: {ready,ej5,ej10,done,short,rem}=%b, required %b",
                 g, {rdy[g], e5[g], e10[g], dn[g], sh[g], rem[g]}, {5'b10000, {AMT_W{1'b0}}});
      end
      n_vec++;
      if (i5[g] !== CNT_W'(I5[g]) || i10[g] !== CNT_W'(I10[g])) begin
        n_err++;
        $display("FAIL reset_inventory dut%0d: inv5=%0d inv10=%0d, required %0d %0d",
                 g, i5[g], i10[g], I5[g], I10[g]);
      end
      n_vec++;
      if (st[g] !== IDLE) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got %0d, required %0d", g, st[g], IDLE);
      end
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int lat, p10, p5;
    logic s;
    logic [AMT_W-1:0] rm;
    run_req(0, 3, 1'b0, lat, p10, p5, s, rm);
    n_vec++;
    if (lat != 16 || p10 != 1 || p5 != 1 || s !== 1'b0) begin
      n_err++;
      $display("FAIL basic_amt3: lat=%0d p10=%0d p5=%0d short=%b, required 16 1 1 0", lat, p10, p5, s);
    end
    n_vec++;
    if (i10[0] !== 8'd19 || i5[0] !== 8'd19) begin
      n_err++;
      $display("FAIL basic_inventory: inv10=%0d inv5=%0d, required 19 19", i10[0], i5[0]);
    end
  endtask

  task automatic test_ten_then_fives();
    int lat, p10, p5;
    logic s;
    logic [AMT_W-1:0] rm;
    run_req(1, 4, 1'b0, lat, p10, p5, s, rm);
    n_vec++;
    if (lat != 23 || p10 != 1 || p5 != 2 || s !== 1'b0) begin
      n_err++;
      $display("FAIL ten_then_fives: lat=%0d p10=%0d p5=%0d short=%b, required 23 1 2 0", lat, p10, p5, s);
    end
    n_vec++;
    if (i10[1] !== 8'd0 || i5[1] !== 8'd18) begin
      n_err++;
      $display("FAIL ten_then_fives_inventory: inv10=%0d inv5=%0d, required 0 18", i10[1], i5[1]);
    end
  endtask

  task automatic test_short();
    int lat, p10, p5;
    logic s;
    logic [AMT_W-1:0] rm;
    run_req(2, 3, 1'b0, lat, p10, p5, s, rm);
    n_vec++;
    if (p10 != 1 || p5 != 0 || s !== 1'b1 || rm !== 4'd1 || i10[2] !== 8'd4) begin
      n_err++;
      $display("FAIL short_odd: p10=%0d p5=%0d short=%b rem=%0d inv10=%0d, required 1 0 1 1 4",
               p10, p5, s, rm, i10[2]);
    end
  endtask

  task automatic test_zero_amount();
    int lat, p10, p5;
    logic s;
    logic [AMT_W-1:0] rm;
    run_req(0, 0, 1'b1, lat, p10, p5, s, rm);
    n_vec++;
    if (lat != 2 || p10 + p5 != 0 || s !== 1'b0) begin
      n_err++;
      $display("FAIL zero_amount: lat=%0d pulses=%0d short=%b, required 2 0 0", lat, p10 + p5, s);
    end
  endtask

  task automatic test_back_to_back();
    int lat, p10, p5;
    logic s;
    logic [AMT_W-1:0] rm;
    run_req(0, 2, 1'b1, lat, p10, p5, s, rm);
    run_req(0, 1, 1'b1, lat, p10, p5, s, rm);
    n_vec++;
    if (p10 != 0 || p5 != 1 || lat != 9) begin
      n_err++;
      $display("FAIL back_to_back_second: p10=%0d p5=%0d lat=%0d, required 0 1 9", p10, p5, lat);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n10, n5, w;
    bit seen;
    n10 = (m10[0] < 2) ? m10[0] : 2;
    n5  = 5 - 2 * n10;
    if (n5 > m5[0]) n5 = m5[0];
    @(negedge clk);
    w = 0;
    while (rdy[0] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    rv[0] = 1'b1;
    ra[0] = 4'd5;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({e10[0], e5[0]} !== exp_eject(3, n10, n5)) begin
      n_err++;
      $display("FAIL mid_pulse_active: {ej10,ej5}=%b, required %b", {e10[0], e5[0]}, exp_eject(3, n10, n5));
    end
    rst = 1'b0;
    @(negedge clk);
    rv[0] = 1'b0;
    n_vec++;
    if ({e10[0], e5[0], dn[0], rdy[0]} !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_pulse_reset: {ej10,ej5,done,ready}=%b, required 0001", {e10[0], e5[0], dn[0], rdy[0]});
    end
    n_vec++;
    if (i10[0] !== CNT_W'(I10[0]) || i5[0] !== CNT_W'(I5[0])) begin
      n_err++;
      $display("FAIL mid_pulse_inventory: inv10=%0d inv5=%0d, required %0d %0d", i10[0], i5[0], I10[0], I5[0]);
    end
    rst = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dn[0] === 1'b1 || st[0] !== IDLE) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL mid_pulse_abandon: done or activity seen after reset, required none");
    end
  endtask

`ifdef COIN_DISP_REFILL_EN
  task automatic test_refill();
    int w;
    @(negedge clk);
    w = 0;
    while (rdy[0] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    ld[0] = 1'b1; ld5[0] = 8'd7; ld10[0] = 8'd9;
    rv[0] = 1'b1; ra[0] = 4'd2;
    #1;
    n_vec++;
    if (rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL refill_blocks_ready: got %b, required 0", rdy[0]);
    end
    @(negedge clk);
    ld[0] = 1'b0; rv[0] = 1'b0;
    n_vec++;
    if (i5[0] !== 8'd7 || i10[0] !== 8'd9 || st[0] !== IDLE) begin
      n_err++;
      $display("FAIL refill_idle: inv5=%0d inv10=%0d state=%0d, required 7 9 %0d", i5[0], i10[0], st[0], IDLE);
    end
    m5[0] = 7; m10[0] = 9;
    rv[0] = 1'b1; ra[0] = 4'd2;
    @(negedge clk);
    rv[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (st[0] !== PULSE) begin
      n_err++;
      $display("FAIL refill_setup_pulse: state=%0d, required %0d", st[0], PULSE);
    end
    ld[0] = 1'b1; ld5[0] = 8'd3; ld10[0] = 8'd3;
    @(negedge clk);
    ld[0] = 1'b0;
    w = 0;
    while (dn[0] !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (dn[0] !== 1'b1) begin
      n_err++;
      $display("FAIL refill_done_timeout: done=%b, required 1", dn[0]);
    end
    m10[0] = 8;
    n_vec++;
    if (i5[0] !== 8'd7 || i10[0] !== 8'd8) begin
      n_err++;
      $display("FAIL refill_ignored_busy: inv5=%0d inv10=%0d, required 7 8", i5[0], i10[0]);
    end
  endtask
`endif

  task automatic test_random();
    int lat, p10, p5;
    logic s;
    logic [AMT_W-1:0] rm;
    for (int i = 0; i < 40; i++) begin
      run_req($urandom_range(0, ND - 1), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              lat, p10, p5, s, rm);
    end
  endtask

  initial begin
    for (int g = 0; g < ND; g++) begin
      rv[g] = 1'b0;
      ra[g] = '0;
`ifdef COIN_DISP_REFILL_EN
      ld[g]   = 1'b0;
      ld5[g]  = '0;
      ld10[g] = '0;
`endif
    end
    model_reset();
    test_reset();
    test_basic();
    test_ten_then_fives();
    test_short();
    test_zero_amount();
    test_back_to_back();
    test_reset_mid_pulse();
`ifdef COIN_DISP_REFILL_EN
    test_refill();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
